// File: rtl/decode_pkg.sv
// decode_pkg -- shared constants and types for the decode queue.
//   DQ_DEPTH / DQ_INSTR_W / DQ_PC_W : default queue geometry
//   POP_NONE / POP_ONE / POP_TWO    : legal POP_REQ encodings (3 is illegal)
//   entry_t                         : one queued instruction {instr, pc}
package decode_pkg;

  localparam int DQ_DEPTH   = 8;
  localparam int DQ_INSTR_W = 32;
  localparam int DQ_PC_W    = 32;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef struct packed {
    logic [DQ_INSTR_W-1:0] instr;
    logic [DQ_PC_W-1:0]    pc;
  } entry_t;

endpackage

// File: rtl/dq_storage.sv
// dq_storage -- DEPTH-entry register file backing the decode queue.
//   CLK              : clock
//   we/waddr         : single write port (instr + pc written together)
//   winstr/wpc       : write data
//   raddr0/raddr1    : two asynchronous read addresses (head, head+1)
//   rinstr*/rpc*     : read data
// Contents are never cleared; the owner tracks validity through its count.
module dq_storage #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] winstr,
  input  logic [PC_W-1:0]    wpc,
  input  logic [AW-1:0]      raddr0,
  input  logic [AW-1:0]      raddr1,
  output logic [INSTR_W-1:0] rinstr0,
  output logic [PC_W-1:0]    rpc0,
  output logic [INSTR_W-1:0] rinstr1,
  output logic [PC_W-1:0]    rpc1
);

  logic [DEPTH-1:0][INSTR_W-1:0] instr_mem;
  logic [DEPTH-1:0][PC_W-1:0]    pc_mem;

  always_ff @(posedge CLK) begin
    if (we) begin
      instr_mem[waddr] <= winstr;
      pc_mem[waddr]    <= wpc;
    end
  end

  assign rinstr0 = instr_mem[raddr0];
  assign rpc0    = pc_mem[raddr0];
  assign rinstr1 = instr_mem[raddr1];
  assign rpc1    = pc_mem[raddr1];

endmodule

// File: rtl/decode_queue_n.sv
// decode_queue_n -- IF->ID instruction queue, 1 push / up to 2 pops per cycle.
//   CLK, RESET (sync, active-low), FLUSH (sync queue clear, wins over push/pop)
//   PUSH_VALID/PUSH_INSTR/PUSH_PC : write request; PUSH_READY = not full
//   POP_REQ     : entries consumed by ID this cycle (0..2, 3 illegal)
//   OUT0_*/OUT1_* : show-ahead head and head+1; data forced to 0 when invalid
//   COUNT       : occupancy, ALMOST_FULL = COUNT >= AF_THRESH
//   POP_ERR     : one-cycle pulse after an illegal or excess pop request
// Outputs depend only on registered state, so a push is visible one cycle
// later and PUSH_READY has no path from POP_REQ.
module decode_queue_n
  import decode_pkg::*;
#(
  parameter int DEPTH     = DQ_DEPTH,
  parameter int INSTR_W   = DQ_INSTR_W,
  parameter int PC_W      = DQ_PC_W,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     PUSH_VALID,
  input  logic [INSTR_W-1:0]       PUSH_INSTR,
  input  logic [PC_W-1:0]          PUSH_PC,
  output logic                     PUSH_READY,
  input  logic [1:0]               POP_REQ,
  output logic                     OUT0_VALID,
  output logic [INSTR_W-1:0]       OUT0_INSTR,
  output logic [PC_W-1:0]          OUT0_PC,
  output logic                     OUT1_VALID,
  output logic [INSTR_W-1:0]       OUT1_INSTR,
  output logic [PC_W-1:0]          OUT1_PC,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     ALMOST_FULL,
  output logic                     POP_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q;
  logic               pop_err_q;
  logic               push_fire;
  logic               pop_bad;
  logic [1:0]         eff_pop;
  logic [INSTR_W-1:0] rinstr0, rinstr1;
  logic [PC_W-1:0]    rpc0, rpc1;

  assign PUSH_READY = (count_q != CW'(DEPTH));
  assign push_fire  = PUSH_VALID && PUSH_READY;

  // Effective pop = min(POP_REQ, COUNT); the illegal code 3 pops nothing.
  always_comb begin
    eff_pop = POP_NONE;
    case (POP_REQ)
      POP_ONE: eff_pop = (count_q != '0) ? POP_ONE : POP_NONE;
      POP_TWO: begin
        if (count_q >= CW'(2))       eff_pop = POP_TWO;
        else if (count_q == CW'(1))  eff_pop = POP_ONE;
        else                         eff_pop = POP_NONE;
      end
      default: eff_pop = POP_NONE;
    endcase
  end

  assign pop_bad = (POP_REQ == 2'd3) || (CW'(POP_REQ) > count_q);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else if (FLUSH) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      // Power-of-2 depth: pointer arithmetic wraps naturally.
      if (push_fire) tail_q <= tail_q + AW'(1);
      head_q    <= head_q + AW'(eff_pop);
      count_q   <= count_q + CW'(push_fire) - CW'(eff_pop);
      pop_err_q <= pop_bad;
    end
  end

  dq_storage #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W),
    .PC_W   (PC_W)
  ) u_storage (
    .CLK    (CLK),
    .we     (push_fire && RESET && !FLUSH),
    .waddr  (tail_q),
    .winstr (PUSH_INSTR),
    .wpc    (PUSH_PC),
    .raddr0 (head_q),
    .raddr1 (head_q + AW'(1)),
    .rinstr0(rinstr0),
    .rpc0   (rpc0),
    .rinstr1(rinstr1),
    .rpc1   (rpc1)
  );

  assign OUT0_VALID  = (count_q != '0);
  assign OUT1_VALID  = (count_q >= CW'(2));
  assign OUT0_INSTR  = OUT0_VALID ? rinstr0 : '0;
  assign OUT0_PC     = OUT0_VALID ? rpc0    : '0;
  assign OUT1_INSTR  = OUT1_VALID ? rinstr1 : '0;
  assign OUT1_PC     = OUT1_VALID ? rpc1    : '0;
  assign COUNT       = count_q;
  assign ALMOST_FULL = (count_q >= CW'(AF_THRESH));
  assign POP_ERR     = pop_err_q;

endmodule

// File: tb/tb_decode_queue_n.sv
// tb_decode_queue_n -- self-checking bench for decode_queue_n (DEPTH=8).
// Directed vector table, hand-written corner sequences and a randomized run,
// all compared against a queue-based reference model.
module tb_decode_queue_n;
  import decode_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET, FLUSH, PUSH_VALID, PUSH_READY;
  logic [31:0]   PUSH_INSTR, PUSH_PC;
  logic [1:0]    POP_REQ;
  logic          OUT0_VALID, OUT1_VALID, ALMOST_FULL, POP_ERR;
  logic [31:0]   OUT0_INSTR, OUT0_PC, OUT1_INSTR, OUT1_PC;
  logic [CW-1:0] COUNT;

  always #5 CLK = ~CLK;

  decode_queue_n #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32), .AF_THRESH(AF)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .PUSH_VALID(PUSH_VALID), .PUSH_INSTR(PUSH_INSTR), .PUSH_PC(PUSH_PC),
    .PUSH_READY(PUSH_READY), .POP_REQ(POP_REQ),
    .OUT0_VALID(OUT0_VALID), .OUT0_INSTR(OUT0_INSTR), .OUT0_PC(OUT0_PC),
    .OUT1_VALID(OUT1_VALID), .OUT1_INSTR(OUT1_INSTR), .OUT1_PC(OUT1_PC),
    .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL), .POP_ERR(POP_ERR)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered list of held entries plus the error flag.
  entry_t mq[$];
  bit     m_err = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit fl, input bit pv,
                            input logic [31:0] ins, input logic [31:0] pc,
                            input logic [1:0] pop);
    int sz, ep;
    entry_t e;
    sz = mq.size();
    if (!rst || fl) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      m_err = (pop == 2'd3) || (int'(pop) > sz);
      ep = (pop == 2'd3) ? 0 : ((int'(pop) > sz) ? sz : int'(pop));
      for (int k = 0; k < ep; k++) void'(mq.pop_front());
      if (pv && sz != DEPTH) begin
        e.instr = ins;
        e.pc    = pc;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    cmp({tag, ".count"}, COUNT, sz);
    cmp({tag, ".ready"}, PUSH_READY, sz != DEPTH);
    cmp({tag, ".v0"}, OUT0_VALID, sz >= 1);
    cmp({tag, ".i0"}, OUT0_INSTR, (sz >= 1) ? mq[0].instr : 32'h0);
    cmp({tag, ".p0"}, OUT0_PC, (sz >= 1) ? mq[0].pc : 32'h0);
    cmp({tag, ".v1"}, OUT1_VALID, sz >= 2);
    cmp({tag, ".i1"}, OUT1_INSTR, (sz >= 2) ? mq[1].instr : 32'h0);
    cmp({tag, ".p1"}, OUT1_PC, (sz >= 2) ? mq[1].pc : 32'h0);
    cmp({tag, ".af"}, ALMOST_FULL, sz >= AF);
    cmp({tag, ".err"}, POP_ERR, m_err);
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit rst, input bit fl, input bit pv,
                     input logic [31:0] ins, input logic [31:0] pc,
                     input logic [1:0] pop, input string tag);
    RESET = rst; FLUSH = fl; PUSH_VALID = pv;
    PUSH_INSTR = ins; PUSH_PC = pc; POP_REQ = pop;
    model_step(rst, fl, pv, ins, pc, pop);
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic push(input logic [31:0] ins, input string tag);
    cyc(1, 0, 1, ins, ins ^ 32'hFFFF_0000, 2'd0, tag);
  endtask

  task automatic pop(input logic [1:0] n, input string tag);
    cyc(1, 0, 0, 32'h0, 32'h0, n, tag);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 32'h0, 32'h0, 2'd0, "rst");
  endtask

  typedef struct {
    bit          rst, fl, pv;
    logic [31:0] ins, pc;
    logic [1:0]  pop;
    int          e_cnt;
    bit          e_v0;
    logic [31:0] e_i0;
    bit          e_v1;
    logic [31:0] e_i1;
    bit          e_err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    RESET = 1'b0; FLUSH = 1'b0; PUSH_VALID = 1'b0;
    PUSH_INSTR = '0; PUSH_PC = '0; POP_REQ = '0;

    // ---- directed table ----
    //           rst fl pv ins           pc  pop cnt v0 i0           v1 i1           err
    tbl[0]  = '{0, 0, 1, 32'hDEADBEEF, 32'h0, 2'd0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[1]  = '{1, 0, 1, 32'h11111111, 32'h0, 2'd0, 1, 1, 32'h11111111, 0, 32'h0,        0};
    tbl[2]  = '{1, 0, 1, 32'h22222222, 32'h4, 2'd0, 2, 1, 32'h11111111, 1, 32'h22222222, 0};
    tbl[3]  = '{1, 0, 1, 32'h33333333, 32'h8, 2'd1, 2, 1, 32'h22222222, 1, 32'h33333333, 0};
    tbl[4]  = '{1, 0, 0, 32'h0,        32'h0, 2'd2, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[5]  = '{1, 0, 0, 32'h0,        32'h0, 2'd1, 0, 0, 32'h0,        0, 32'h0,        1};
    tbl[6]  = '{1, 0, 1, 32'h44444444, 32'hC, 2'd0, 1, 1, 32'h44444444, 0, 32'h0,        0};
    tbl[7]  = '{1, 0, 0, 32'h0,        32'h0, 2'd2, 0, 0, 32'h0,        0, 32'h0,        1};
    tbl[8]  = '{1, 0, 1, 32'h55555555, 32'h10,2'd0, 1, 1, 32'h55555555, 0, 32'h0,        0};
    tbl[9]  = '{1, 0, 1, 32'h66666666, 32'h14,2'd0, 2, 1, 32'h55555555, 1, 32'h66666666, 0};
    tbl[10] = '{1, 0, 0, 32'h0,        32'h0, 2'd3, 2, 1, 32'h55555555, 1, 32'h66666666, 1};
    tbl[11] = '{1, 1, 1, 32'h88888888, 32'h18,2'd1, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[12] = '{1, 0, 0, 32'h0,        32'h0, 2'd0, 0, 0, 32'h0,        0, 32'h0,        0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].fl, tbl[i].pv, tbl[i].ins, tbl[i].pc, tbl[i].pop,
          $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.cnt", i), COUNT, tbl[i].e_cnt);
      cmp($sformatf("tbl%0d.v0", i), OUT0_VALID, tbl[i].e_v0);
      cmp($sformatf("tbl%0d.i0", i), OUT0_INSTR, tbl[i].e_i0);
      cmp($sformatf("tbl%0d.v1", i), OUT1_VALID, tbl[i].e_v1);
      cmp($sformatf("tbl%0d.i1", i), OUT1_INSTR, tbl[i].e_i1);
      cmp($sformatf("tbl%0d.err", i), POP_ERR, tbl[i].e_err);
    end

    // ---- fill to full, almost-full threshold, dropped 9th push ----
    do_reset();
    cmp("rst.ready", PUSH_READY, 1);
    cmp("rst.af", ALMOST_FULL, 0);
    for (int i = 0; i < DEPTH; i++) begin
      push(32'hA000_0000 + i, $sformatf("fill%0d", i));
      cmp($sformatf("fill%0d.cnt", i), COUNT, i + 1);
      cmp($sformatf("fill%0d.af", i), ALMOST_FULL, (i + 1) >= 6);
    end
    cmp("full.ready", PUSH_READY, 0);
    push(32'hBAD0_0009, "push9");
    cmp("push9.cnt", COUNT, 8);
    cyc(1, 0, 1, 32'hBAD0_000A, 32'h0, 2'd2, "fullpp");
    cmp("fullpp.cnt", COUNT, 6);
    cmp("fullpp.i0", OUT0_INSTR, 32'hA000_0002);
    pop(2'd2, "drain0"); cmp("drain0.i0", OUT0_INSTR, 32'hA000_0004);
    pop(2'd2, "drain1"); cmp("drain1.i1", OUT1_INSTR, 32'hA000_0007);
    pop(2'd2, "drain2"); cmp("drain2.cnt", COUNT, 0);

    // ---- two-entry pop across the wrap point ----
    do_reset();
    for (int i = 0; i < 7; i++) push(32'hC000_0000 + i, "wfill");
    pop(2'd2, "wpop"); pop(2'd2, "wpop"); pop(2'd2, "wpop"); pop(2'd1, "wpop");
    cmp("wrap.empty", COUNT, 0);
    push(32'hD000_0007, "wpush");   // index 7
    push(32'hD000_0000, "wpush");   // index 0
    push(32'hD000_0001, "wpush");   // index 1
    cmp("wrap.cnt3", COUNT, 3);
    pop(2'd2, "wrap");
    cmp("wrap.i0", OUT0_INSTR, 32'hD000_0001);
    cmp("wrap.cnt", COUNT, 1);

    // ---- flush at COUNT=5 beats push+pop ----
    do_reset();
    for (int i = 0; i < 5; i++) push(32'hE000_0000 + i, "ffill");
    cmp("flush.pre", COUNT, 5);
    cyc(1, 1, 1, 32'hE0FF_FFFF, 32'h0, 2'd1, "flush");
    cmp("flush.cnt", COUNT, 0);
    cmp("flush.v0", OUT0_VALID, 0);
    cmp("flush.v1", OUT1_VALID, 0);
    pop(2'd0, "postflush");
    cmp("postflush.cnt", COUNT, 0);

    // ---- reset mid-operation overrides everything ----
    for (int i = 0; i < 3; i++) push(32'hF000_0000 + i, "rfill");
    cyc(0, 1, 1, 32'hF0FF_FFFF, 32'h0, 2'd3, "midrst");
    cmp("midrst.cnt", COUNT, 0);
    cmp("midrst.err", POP_ERR, 0);
    push(32'h1234_5678, "afterrst");
    cmp("afterrst.i0", OUT0_INSTR, 32'h1234_5678);

    // ---- randomized run with fill/drain phases ----
    for (int c = 0; c < 3000; c++) begin
      bit fillph;
      bit rst, fl, pv;
      logic [1:0] pr;
      fillph = ((c / 48) % 2) == 0;
      rst = ($urandom_range(0, 299) != 0);
      fl  = ($urandom_range(0, 99) == 0);
      pv  = fillph ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      pr  = fillph ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 31) == 0) pr = 2'd3;
      cyc(rst, fl, pv, $urandom, $urandom, pr, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
